// File: rtl/pong_pkg.sv
// Shared types and default timing constants for the pong input front end.
package pong_pkg;

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_CHK_HI = 2'd1,
        S_HIGH   = 2'd2,
        S_CHK_LO = 2'd3
    } btn_state_t;

    localparam int PONG_DEBOUNCE_CYCLES = 32'd250000;
    localparam int PONG_REPEAT_DELAY    = 32'd6250000;
    localparam int PONG_REPEAT_PERIOD   = 32'd1250000;

endpackage

// File: rtl/pong_debounce_ch.sv
// One button channel: input synchroniser, debounce FSM and optional auto-repeat.
// The debounce count includes the current sample, so a commit lands DEBOUNCE_CYCLES samples after the first differing one.
module pong_debounce_ch
    import pong_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = PONG_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = PONG_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = PONG_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int              CW           = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ZERO     = {CW{1'b0}};
    localparam int              RMAX         = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int              RW           = $clog2(RMAX + 1);
    localparam logic [RW-1:0]   RPT_DELAY_C  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0]   RPT_PERIOD_C = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0]   RPT_ZERO     = {RW{1'b0}};
    localparam logic [RW-1:0]   RPT_ONE      = RW'(1'b1);
    localparam logic            RPT_ON_C     = (REPEAT_EN != 0);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_sync_s;
    btn_state_t             state_r;
    btn_state_t             state_nx_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_nx_s;
    logic                   rise_s;
    logic                   fall_s;
    logic [RW-1:0]          rpt_cnt_r;
    logic [RW-1:0]          rpt_cnt_nx_s;
    logic [RW-1:0]          rpt_target_s;
    logic                   rpt_on_r;
    logic                   rpt_on_nx_s;
    logic                   rpt_first_r;
    logic                   rpt_first_nx_s;
    logic                   rpt_fire_s;

    assign s_sync_s = sync_r[SYNC_STAGES-1];

    // Debounce FSM next state; ena low collapses check states back to the last stable level
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        rise_s     = 1'b0;
        fall_s     = 1'b0;
        if (!ena) begin
            cnt_nx_s = CNT_ZERO;
            case (state_r)
                S_CHK_HI: state_nx_s = S_LOW;
                S_CHK_LO: state_nx_s = S_HIGH;
                default:  state_nx_s = state_r;
            endcase
        end else begin
            case (state_r)
                S_LOW, S_CHK_HI: begin
                    if (!s_sync_s) begin
                        state_nx_s = S_LOW;
                        cnt_nx_s   = CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nx_s = S_HIGH;
                        cnt_nx_s   = CNT_ZERO;
                        rise_s     = 1'b1;
                    end else begin
                        state_nx_s = S_CHK_HI;
                        cnt_nx_s   = cnt_r + CW'(1'b1);
                    end
                end
                S_HIGH, S_CHK_LO: begin
                    if (s_sync_s) begin
                        state_nx_s = S_HIGH;
                        cnt_nx_s   = CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nx_s = S_LOW;
                        cnt_nx_s   = CNT_ZERO;
                        fall_s     = 1'b1;
                    end else begin
                        state_nx_s = S_CHK_LO;
                        cnt_nx_s   = cnt_r + CW'(1'b1);
                    end
                end
                default: begin
                    state_nx_s = S_LOW;
                    cnt_nx_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Auto-repeat timer; a falling commit clears it first so release always wins
    always_comb begin
        rpt_cnt_nx_s   = rpt_cnt_r;
        rpt_on_nx_s    = rpt_on_r;
        rpt_first_nx_s = rpt_first_r;
        rpt_fire_s     = 1'b0;
        rpt_target_s   = rpt_first_r ? RPT_DELAY_C : RPT_PERIOD_C;
        if (rise_s) begin
            rpt_on_nx_s    = RPT_ON_C;
            rpt_first_nx_s = 1'b1;
            rpt_cnt_nx_s   = RPT_ONE;
        end else if (!ena || (state_nx_s == S_LOW)) begin
            rpt_on_nx_s    = 1'b0;
            rpt_first_nx_s = 1'b0;
            rpt_cnt_nx_s   = RPT_ZERO;
        end else if (rpt_on_r) begin
            if (rpt_cnt_r == rpt_target_s) begin
                rpt_fire_s     = 1'b1;
                rpt_first_nx_s = 1'b0;
                rpt_cnt_nx_s   = RPT_ONE;
            end else begin
                rpt_cnt_nx_s   = rpt_cnt_r + RPT_ONE;
            end
        end else begin
            rpt_cnt_nx_s = RPT_ZERO;
        end
    end

    // Synchroniser, channel state, repeat timer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r      <= {SYNC_STAGES{1'b0}};
            state_r     <= S_LOW;
            cnt_r       <= CNT_ZERO;
            rpt_cnt_r   <= RPT_ZERO;
            rpt_on_r    <= 1'b0;
            rpt_first_r <= 1'b0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], btn_raw};
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            rpt_cnt_r   <= rpt_cnt_nx_s;
            rpt_on_r    <= rpt_on_nx_s;
            rpt_first_r <= rpt_first_nx_s;
            btn_level   <= (state_nx_s == S_HIGH) || (state_nx_s == S_CHK_LO);
            btn_press   <= rise_s || (rpt_fire_s && !fall_s);
            btn_release <= fall_s;
        end
    end

endmodule

// File: rtl/pong_io_frontend.sv
// Input conditioning between the Tiny Tapeout pins and the pong core:
// per-button synchronise/debounce/edge/repeat plus a synchronised core reset.
module pong_io_frontend
    import pong_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = PONG_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = PONG_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = PONG_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               rst_sync_n
);

    logic [SYNC_STAGES-1:0] rst_pipe_r;

    // Reset synchroniser: asserts with rst_n, releases after SYNC_STAGES edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe_r <= {SYNC_STAGES{1'b0}};
        end else begin
            rst_pipe_r <= {rst_pipe_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = rst_pipe_r[SYNC_STAGES-1];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        pong_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .ena        (ena),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i])
        );
    end

endmodule

// File: tb/tb_pong_io_frontend.sv
// Bench for pong_io_frontend: directed scenarios plus random stimulus, all
// outputs compared every cycle against a run-length behavioural model.
module tb_pong_io_frontend;

    localparam int NB = 4;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic          rst_sync_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pong_io_frontend #(
        .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
        .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .rst_sync_n(rst_sync_n)
    );

    // Model: raw samples delayed SS edges, then level flips once DB consecutive samples disagree with it
    logic [NB-1:0] hist [$];
    bit            m_level [NB];
    int            m_run   [NB];
    bit            m_rpt   [NB];
    int            m_since [NB];
    bit            m_first [NB];
    logic [NB-1:0] e_level, e_press, e_release;
    int            rst_edges;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < SS; k++) hist.push_back('0);
        for (int c = 0; c < NB; c++) begin
            m_level[c] = 1'b0; m_run[c] = 0; m_rpt[c] = 1'b0; m_since[c] = 0; m_first[c] = 1'b0;
        end
        e_level = '0; e_press = '0; e_release = '0;
        rst_edges = 0;
    endtask

    task automatic model_edge();
        logic [NB-1:0] s;
        s = hist.pop_front();
        hist.push_back(btn_raw);
        rst_edges++;
        for (int c = 0; c < NB; c++) begin
            e_press[c] = 1'b0;
            e_release[c] = 1'b0;
            if (!ena) begin
                m_run[c] = 0;
                m_rpt[c] = 1'b0;
            end else begin
                if (s[c] != m_level[c]) m_run[c]++;
                else m_run[c] = 0;
                if (m_run[c] == DB) begin
                    m_level[c] = s[c];
                    m_run[c] = 0;
                    if (s[c]) begin
                        e_press[c] = 1'b1; m_rpt[c] = 1'b1; m_since[c] = 0; m_first[c] = 1'b1;
                    end else begin
                        e_release[c] = 1'b1; m_rpt[c] = 1'b0;
                    end
                end else if (m_rpt[c]) begin
                    m_since[c]++;
                    if (m_since[c] == (m_first[c] ? RD : RP)) begin
                        e_press[c] = 1'b1; m_since[c] = 0; m_first[c] = 1'b0;
                    end
                end
            end
            e_level[c] = m_level[c];
        end
    endtask

    task automatic compare();
        chk("level",    32'(btn_level),   32'(e_level));
        chk("press",    32'(btn_press),   32'(e_press));
        chk("release",  32'(btn_release), 32'(e_release));
        chk("rst_sync", 32'(rst_sync_n),  (rst_edges >= SS) ? 32'd1 : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        compare();
    endtask

    initial begin
        int   t_press;
        int   t_rel;
        int   q;
        int   got_q [$];
        int   exp_q [$];
        logic seen;

        rst_n = 1'b0; ena = 1'b1; btn_raw = '1;
        model_reset();

        // Reset with all buttons held
        repeat (3) tick();
        rst_n = 1'b1;
        t_press = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) chk("rst_sync_edge1", 32'(rst_sync_n), 32'd0);
            if (i == 2) chk("rst_sync_edge2", 32'(rst_sync_n), 32'd1);
            if (i == 6) chk("rst_level_all", 32'(btn_level), 32'hF);
            if (i == 7) chk("rst_press_width", 32'(btn_press), 32'h0);
            if (t_press == 0 && btn_press == 4'hF) t_press = i;
        end
        chk("rst_press_lat", t_press, SS + DB);
        btn_raw = '0;
        repeat (10) tick();

        // Glitch rejection, then a pulse just long enough to commit
        seen = 1'b0;
        for (int i = 0; i < 13; i++) begin
            btn_raw[0] = (i < 3);
            tick();
            if (btn_press[0] || btn_level[0]) seen = 1'b1;
        end
        chk("glitch_reject", 32'(seen), 32'd0);
        t_press = 0; t_rel = 0;
        for (int i = 1; i <= 14; i++) begin
            btn_raw[0] = (i <= 4);
            tick();
            if (btn_press[0] && t_press == 0) t_press = i;
            if (btn_release[0] && t_rel == 0) t_rel = i;
        end
        chk("pulse4_press", t_press, 6);
        chk("pulse4_release", t_rel, 10);

        // Auto-repeat; hold chosen so a repeat would land on the release cycle
        t_rel = 0; seen = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            btn_raw[1] = (i <= 32);
            tick();
            if (btn_press[1]) got_q.push_back(i);
            if (btn_release[1] && t_rel == 0) t_rel = i;
            if (btn_release[1] && btn_press[1]) seen = 1'b1;
        end
        chk("rpt_release", t_rel, 33 + SS + DB - 1);
        exp_q.push_back(SS + DB);
        q = SS + DB + RD;
        while (q < 33 + SS + DB - 1) begin
            exp_q.push_back(q);
            q += RP;
        end
        chk("rpt_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) chk("rpt_edge", got_q[k], exp_q[k]);
        chk("rpt_release_wins", 32'(seen), 32'd0);

        // Simultaneous rise on ch2 and fall on ch3
        btn_raw[3] = 1'b1;
        repeat (10) tick();
        btn_raw[2] = 1'b1; btn_raw[3] = 1'b0;
        t_press = 0; t_rel = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (btn_press[2] && t_press == 0) t_press = i;
            if (btn_release[3] && t_rel == 0) t_rel = i;
        end
        chk("simul_press2", t_press, 6);
        chk("simul_release3", t_rel, 6);
        btn_raw[2] = 1'b0;
        repeat (10) tick();

        // ena drop in the middle of a debounce
        btn_raw[0] = 1'b1;
        repeat (4) tick();
        ena = 1'b0; seen = 1'b0;
        repeat (10) begin
            tick();
            if (btn_press != '0 || btn_release != '0) seen = 1'b1;
        end
        chk("ena_quiet", 32'(seen), 32'd0);
        ena = 1'b1; t_press = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (btn_press[0] && t_press == 0) t_press = i;
        end
        chk("ena_restart", t_press, DB);
        btn_raw[0] = 1'b0;
        repeat (10) tick();

        // Asynchronous reset during the repeat phase
        btn_raw[1] = 1'b1;
        repeat (20) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(btn_level), 32'd0);
        chk("arst_press", 32'(btn_press), 32'd0);
        chk("arst_release", 32'(btn_release), 32'd0);
        chk("arst_sync", 32'(rst_sync_n), 32'd0);
        model_reset();
        btn_raw = '0;
        repeat (3) tick();
        rst_n = 1'b1; seen = 1'b0;
        repeat (15) begin
            tick();
            if (btn_press != '0 || btn_release != '0) seen = 1'b1;
        end
        chk("post_rst_quiet", 32'(seen), 32'd0);

        // Random toggling of buttons and enable
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(5) == 0) btn_raw[c] = ~btn_raw[c];
            end
            if ($urandom_range(39) == 0) ena = ~ena;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
